gate_deadtime_monitor: RTL and testbench
========================================

Name: gate_deadtime_monitor

Overview:
- Receive-side counterpart of the per-leg gate driver. It watches the Q1/Q2 gate signal pair of one inverter leg and rebuilds the commanded leg state.
- It measures every dead-time interval in clock cycles, flags intervals shorter than a programmed minimum, and flags shoot-through.
- One instance per leg sits in the inverter IP. It taps either the driver outputs or the gate-feedback pins; its fault output feeds the PWM enable logic.

Parameters:
- CNT_W, 16, width of the dead-time counter and of deadtime_min / dt_last.

Ports:
- CLK  in  1  system clock, 200 MHz max.
- RST  in  1  asynchronous reset, active-high.
- Q1_in  in  1  top-switch gate signal.
- Q2_in  in  1  bottom-switch gate signal.
- deadtime_min  in  CNT_W  minimum legal dead time in cycles; quasi-static.
- clr  in  1  single-cycle pulse; clears sticky faults.
- Sout  out  1  reconstructed leg state.
- dt_last  out  CNT_W  length of the most recent dead-time interval, in cycles.
- dt_valid  out  1  one-cycle pulse when dt_last updates.
- shoot_through  out  1  sticky; Q1 and Q2 were sampled high together.
- dt_short  out  1  sticky; a side change had dead time below deadtime_min.
- fault  out  1  shoot_through OR dt_short.

Behaviour:
- Interface: one clock, CLK. Reset RST is asynchronous and active-high.
- Reset values: state = OFF, Sout = 0, dt_last = 0, dt_valid = 0, shoot_through = 0, dt_short = 0, fault = 0, dt_count = 0, last_side = NONE.
- Sampling: s = {Q1,Q2} is registered every edge, giving one cycle of capture. The FSM acts on s at the next edge, so outputs reflect a pin change 2 edges later (3 with GATE_SYNC_EN).
- dt_count counts sampled 00 cycles. It saturates at 2^CNT_W-1 and never wraps.
- FSM states: OFF, TOP, BOT, FAULT. Priority at each edge: s = 11 in any non-FAULT state goes to FAULT and sets shoot_through; Sout holds its value.
- OFF, s = 00: stay; dt_count increments (saturating).
- OFF, s = 10: go to TOP.
  - dt_last <= dt_count; dt_valid pulses.
  - If last_side = BOT and dt_count < deadtime_min, set dt_short.
  - last_side <= TOP; Sout <= 1; dt_count <= 0.
- OFF, s = 01: mirror of the s = 10 case. Go to BOT; the short check applies when last_side = TOP; last_side <= BOT; Sout <= 0.
- TOP, s = 10: stay.
- TOP, s = 00: go to OFF; dt_count <= 1.
- TOP, s = 01: direct side change with zero dead time. Go to BOT; dt_last <= 0; dt_valid pulses; set dt_short unconditionally; Sout <= 0; last_side <= BOT.
- BOT: symmetric to TOP.
- Same-side re-entry (TOP -> OFF -> TOP): dt_last updates, but no short check. A gate glitch is not a dead-time violation.
- First turn-on after reset or clr: last_side = NONE, so the interval is never checked.
- dt_short does not change state; monitoring continues.
- FAULT: hold. Leave only on clr = 1 with s != 11.
  - Next state: OFF.
  - Clears both sticky flags; dt_count <= 0; last_side <= NONE; Sout held.
- clr with s = 11: no effect; stay in FAULT.
- clr outside FAULT: clears dt_short and shoot_through; state, dt_count and last_side are untouched.
- If clr and a new violation land on the same edge, the set wins.
- fault is registered and asserts on the same edge as the flag it reflects.
- Async RST mid-interval: everything returns to reset values immediately and any partial count is discarded.

Optional Feature:
- Macro: GATE_SYNC_EN.
- Defined: Q1_in/Q2_in pass through a 2-flop synchronizer ahead of the sample register. This adds one edge of latency (3 total) and is required when the inputs are the async gate-feedback pins.
- Undefined: a single sample register only (2-edge latency), for inputs already in the CLK domain.
- Both settings give identical dt_last values for clean, noise-free edges.

Decomposition:
- Shared package (inverter_pkg): FSM state encodings (OFF = 0, TOP = 1, BOT = 2, FAULT = 3), last_side encodings (NONE, TOP, BOT), default CNT_W = 16.
- One sub-module, gate_sync2: a parameterised-width 2-flop synchronizer with async active-high reset to 0. It is instantiated only under GATE_SYNC_EN.

Test Plan:
- Normal switching, deadtime_min = 25: Q1 high, then 00 for 30 cycles, then Q2 high. Expect dt_last = 30, one dt_valid pulse, dt_short = 0, Sout 1 -> 0.
- Short dead time, deadtime_min = 25: BOT, then 00 for 24 cycles, then TOP. Expect dt_last = 24, dt_short = 1, fault = 1, Sout = 1, FSM still tracking. Then clr: flags return to 0.
- Shoot-through: from TOP, drive 11 for 1 cycle, then 00. Expect FAULT state, shoot_through = 1, Sout held at 1. clr while 11 is held: no change. clr after 00: state OFF, flags 0.
- Direct change: TOP -> 01 with no gap. Expect dt_last = 0, dt_short = 1 even with deadtime_min = 0.
- Saturation and first edge: hold 00 for 70000 cycles after reset, then 10. Expect dt_last = 65535, no dt_short because last_side = NONE.
- Latency: single-edge check, 2-cycle response without GATE_SYNC_EN, 3-cycle with it. Assert RST mid-interval: all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/inverter_pkg.sv
// Shared encodings for the inverter leg IP: leg FSM states, last-driven side
// and the sampled {Q1,Q2} gate patterns.
package inverter_pkg;

    localparam int CNT_W_DEFAULT = 16;

    // Leg monitor FSM states; encodings are fixed so software/debug taps can
    // decode them directly.
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_TOP   = 2'd1,
        ST_BOT   = 2'd2,
        ST_FAULT = 2'd3
    } leg_state_e;

    // Side that was driven most recently; NONE after reset or fault recovery.
    typedef enum logic [1:0] {
        SIDE_NONE = 2'd0,
        SIDE_TOP  = 2'd1,
        SIDE_BOT  = 2'd2
    } side_e;

    // Sampled gate patterns, ordered {Q1,Q2}.
    localparam logic [1:0] S_DEAD  = 2'b00;
    localparam logic [1:0] S_TOP   = 2'b10;
    localparam logic [1:0] S_BOT   = 2'b01;
    localparam logic [1:0] S_SHOOT = 2'b11;

endpackage

// File: rtl/gate_sync2.sv
// Parameterised-width two-flop synchronizer, asynchronous active-high reset
// to zero. Used on the gate-feedback path when the pins are not in CLK domain.
module gate_sync2 #(
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops give metastable samples a full cycle to settle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/gate_deadtime_monitor.sv
// Per-leg gate dead-time monitor. Rebuilds the commanded leg state from the
// Q1/Q2 gate pair, measures each dead-time interval, and raises sticky
// shoot-through / short-dead-time flags that feed the PWM enable logic.
// Build option: define GATE_SYNC_EN to put a two-flop synchronizer on the
// gate inputs (needed when tapping the asynchronous gate-feedback pins).
module gate_deadtime_monitor
    import inverter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Q1_in,
    input  logic             Q2_in,
    input  logic [CNT_W-1:0] deadtime_min,
    input  logic             clr,
    output logic             Sout,
    output logic [CNT_W-1:0] dt_last,
    output logic             dt_valid,
    output logic             shoot_through,
    output logic             dt_short,
    output logic             fault
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Sampled {Q1,Q2}; the FSM only ever looks at this registered copy.
    logic [1:0] s_q;

`ifdef GATE_SYNC_EN
    // The synchronizer's output stage doubles as the sample register, so the
    // async pins cost exactly one extra edge of latency.
    gate_sync2 #(
        .WIDTH(2)
    ) u_gate_sync2 (
        .clk_i(CLK),
        .rst_i(RST),
        .d_i  ({Q1_in, Q2_in}),
        .q_o  (s_q)
    );
`else
    // Inputs already live in the CLK domain: one capture register is enough.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s_q <= S_DEAD;
        end else begin
            s_q <= {Q1_in, Q2_in};
        end
    end
`endif

    leg_state_e       state_q, state_d;
    side_e            last_side_q, last_side_d;
    logic [CNT_W-1:0] dt_count_q, dt_count_d;
    logic [CNT_W-1:0] dt_last_q, dt_last_d;
    logic             dt_valid_q, dt_valid_d;
    logic             sout_q, sout_d;
    logic             shoot_q, shoot_d;
    logic             short_q, short_d;
    logic             fault_q, fault_d;
    logic             shoot_set, short_set, flag_clr;

    // Next-state and datapath decode for the leg FSM.
    always_comb begin
        state_d     = state_q;
        last_side_d = last_side_q;
        dt_count_d  = dt_count_q;
        dt_last_d   = dt_last_q;
        dt_valid_d  = 1'b0;
        sout_d      = sout_q;
        shoot_set   = 1'b0;
        short_set   = 1'b0;
        flag_clr    = clr;

        if (state_q == ST_FAULT) begin
            // Recovery is refused while the pins still show both gates on.
            flag_clr = clr && (s_q != S_SHOOT);
            if (flag_clr) begin
                state_d     = ST_OFF;
                dt_count_d  = '0;
                last_side_d = SIDE_NONE;
            end
        end else if (s_q == S_SHOOT) begin
            // Shoot-through outranks everything; Sout keeps its last value.
            state_d   = ST_FAULT;
            shoot_set = 1'b1;
        end else begin
            case (state_q)
                ST_OFF: begin
                    case (s_q)
                        S_TOP: begin
                            state_d     = ST_TOP;
                            dt_last_d   = dt_count_q;
                            dt_valid_d  = 1'b1;
                            // Only a genuine side change is checked; re-entry
                            // on the same side is treated as a gate glitch.
                            short_set   = (last_side_q == SIDE_BOT) &&
                                          (dt_count_q < deadtime_min);
                            last_side_d = SIDE_TOP;
                            sout_d      = 1'b1;
                            dt_count_d  = '0;
                        end
                        S_BOT: begin
                            state_d     = ST_BOT;
                            dt_last_d   = dt_count_q;
                            dt_valid_d  = 1'b1;
                            short_set   = (last_side_q == SIDE_TOP) &&
                                          (dt_count_q < deadtime_min);
                            last_side_d = SIDE_BOT;
                            sout_d      = 1'b0;
                            dt_count_d  = '0;
                        end
                        default: begin
                            // Saturate rather than wrap so a long idle leg
                            // never looks like a short interval.
                            if (dt_count_q != CNT_MAX) begin
                                dt_count_d = dt_count_q + CNT_W'(1);
                            end
                        end
                    endcase
                end
                ST_TOP: begin
                    case (s_q)
                        S_DEAD: begin
                            // This edge already saw the first dead cycle.
                            state_d    = ST_OFF;
                            dt_count_d = CNT_W'(1);
                        end
                        S_BOT: begin
                            // Hard commutation with no dead time at all.
                            state_d     = ST_BOT;
                            dt_last_d   = '0;
                            dt_valid_d  = 1'b1;
                            short_set   = 1'b1;
                            sout_d      = 1'b0;
                            last_side_d = SIDE_BOT;
                            dt_count_d  = '0;
                        end
                        default: ;
                    endcase
                end
                ST_BOT: begin
                    case (s_q)
                        S_DEAD: begin
                            state_d    = ST_OFF;
                            dt_count_d = CNT_W'(1);
                        end
                        S_TOP: begin
                            state_d     = ST_TOP;
                            dt_last_d   = '0;
                            dt_valid_d  = 1'b1;
                            short_set   = 1'b1;
                            sout_d      = 1'b1;
                            last_side_d = SIDE_TOP;
                            dt_count_d  = '0;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end

        // A new violation on the same edge as clr wins over the clear.
        shoot_d = (shoot_q & ~flag_clr) | shoot_set;
        short_d = (short_q & ~flag_clr) | short_set;
        fault_d = shoot_d | short_d;
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and sticky flag registers; fault is registered alongside them.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_side_q <= SIDE_NONE;
            dt_count_q  <= '0;
            dt_last_q   <= '0;
            dt_valid_q  <= 1'b0;
            sout_q      <= 1'b0;
            shoot_q     <= 1'b0;
            short_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            last_side_q <= last_side_d;
            dt_count_q  <= dt_count_d;
            dt_last_q   <= dt_last_d;
            dt_valid_q  <= dt_valid_d;
            sout_q      <= sout_d;
            shoot_q     <= shoot_d;
            short_q     <= short_d;
            fault_q     <= fault_d;
        end
    end

    assign Sout          = sout_q;
    assign dt_last       = dt_last_q;
    assign dt_valid      = dt_valid_q;
    assign shoot_through = shoot_q;
    assign dt_short      = short_q;
    assign fault         = fault_q;

endmodule

// File: tb/tb_gate_deadtime_monitor.sv
// Self-checking bench for gate_deadtime_monitor: directed scenarios with
// hand-derived expectations plus randomized switching checked every cycle
// against a behavioural model of the leg.
module tb_gate_deadtime_monitor;

    localparam int CNT_W = 16;
`ifdef GATE_SYNC_EN
    localparam int X = 1;   // extra input latency in edges
`else
    localparam int X = 0;
`endif

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             Q1_in = 1'b0;
    logic             Q2_in = 1'b0;
    logic [CNT_W-1:0] deadtime_min = '0;
    logic             clr = 1'b0;
    logic             Sout;
    logic [CNT_W-1:0] dt_last;
    logic             dt_valid;
    logic             shoot_through;
    logic             dt_short;
    logic             fault;

    gate_deadtime_monitor #(.CNT_W(CNT_W)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Q1_in        (Q1_in),
        .Q2_in        (Q2_in),
        .deadtime_min (deadtime_min),
        .clr          (clr),
        .Sout         (Sout),
        .dt_last      (dt_last),
        .dt_valid     (dt_valid),
        .shoot_through(shoot_through),
        .dt_short     (dt_short),
        .fault        (fault)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int valid_pulses = 0;

    // Behavioural model: the leg is described by which side is on, how many
    // dead cycles have been seen, and which side was last driven.
    logic [1:0] hist [0:1];
    int  m_on;       // 0 none on, 1 top on, 2 bottom on
    int  m_last;     // 0 none, 1 top, 2 bottom
    int  m_zeros;    // dead cycles seen (unbounded, clipped when reported)
    bit  m_fault, m_sout, m_dtv, m_st, m_ds;
    int  m_dtlast;

    function automatic void model_reset();
        hist[0] = 2'b00; hist[1] = 2'b00;
        m_on = 0; m_last = 0; m_zeros = 0; m_fault = 0;
        m_sout = 0; m_dtv = 0; m_st = 0; m_ds = 0; m_dtlast = 0;
    endfunction

    function automatic void model_edge(logic [1:0] pins, bit c);
        logic [1:0] s;
        int want, dt, cnt;
        bit set_st, set_ds;
        s = hist[X];
        for (int i = X; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = pins;
        set_st = 0; set_ds = 0; m_dtv = 0;
        if (m_fault) begin
            if (c && s != 2'b11) begin
                m_fault = 0; m_st = 0; m_ds = 0; m_zeros = 0; m_last = 0; m_on = 0;
            end
            return;
        end
        if (s == 2'b11) begin
            m_fault = 1; set_st = 1;
        end else begin
            want = (s == 2'b10) ? 1 : (s == 2'b01) ? 2 : 0;
            if (want == 0) begin
                m_zeros = (m_on != 0) ? 1 : m_zeros + 1;
                m_on = 0;
            end else if (want != m_on) begin
                cnt = (m_zeros > 65535) ? 65535 : m_zeros;
                dt = (m_on == 0) ? cnt : 0;
                if (m_on != 0) set_ds = 1;
                else if (m_last != 0 && m_last != want && dt < int'(deadtime_min)) set_ds = 1;
                m_dtlast = dt; m_dtv = 1; m_last = want;
                m_sout = (want == 1); m_zeros = 0; m_on = want;
            end
        end
        if (c) begin m_st = 0; m_ds = 0; end
        m_st = m_st | set_st;
        m_ds = m_ds | set_ds;
    endfunction

    task automatic do_reset();
        RST = 1'b1; Q1_in = 1'b0; Q2_in = 1'b0; clr = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0;
        model_reset();
    endtask

    task automatic step(input bit q1, input bit q2, input bit c);
        Q1_in = q1; Q2_in = q2; clr = c;
        @(posedge CLK);
        model_edge({q1, q2}, c);
        #1;
        clr = 1'b0;
        if (dt_valid === 1'b1) valid_pulses++;
    endtask

    task automatic hold(input bit q1, input bit q2, input int n);
        for (int i = 0; i < n; i++) step(q1, q2, 1'b0);
    endtask

    task automatic test_reset();
        RST = 1'b1; #1;
        checks++;
        if ({Sout, dt_last, dt_valid, shoot_through, dt_short, fault} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {Sout, dt_last, dt_valid, shoot_through, dt_short, fault});
        end
        do_reset();
        $display("test_reset done");
    endtask

    task automatic test_normal();
        do_reset();
        deadtime_min = 16'd25;
        hold(1, 0, 3);
        checks++;
        if (Sout !== 1'b1) begin failures++; $display("FAIL normal_sout_top got=%0d exp=1", Sout); end
        valid_pulses = 0;
        hold(0, 0, 30);
        hold(0, 1, 1 + 1 + X);
        checks++;
        if (dt_last !== 16'd30) begin failures++; $display("FAIL normal_dt_last got=%0d exp=30", dt_last); end
        checks++;
        if (dt_valid !== 1'b1) begin failures++; $display("FAIL normal_dt_valid got=%0d exp=1", dt_valid); end
        checks++;
        if (Sout !== 1'b0) begin failures++; $display("FAIL normal_sout_bot got=%0d exp=0", Sout); end
        checks++;
        if (dt_short !== 1'b0) begin failures++; $display("FAIL normal_dt_short got=%0d exp=0", dt_short); end
        hold(0, 1, 2);
        checks++;
        if (valid_pulses != 1) begin failures++; $display("FAIL normal_pulse_count got=%0d exp=1", valid_pulses); end
        $display("txn normal dt_last=%0d", dt_last);
    endtask

    task automatic test_short();
        // Continues from the bottom-side state left by test_normal.
        hold(0, 0, 24);
        hold(1, 0, 1 + 1 + X);
        checks++;
        if (dt_last !== 16'd24) begin failures++; $display("FAIL short_dt_last got=%0d exp=24", dt_last); end
        checks++;
        if (dt_short !== 1'b1) begin failures++; $display("FAIL short_flag got=%0d exp=1", dt_short); end
        checks++;
        if (fault !== 1'b1) begin failures++; $display("FAIL short_fault got=%0d exp=1", fault); end
        checks++;
        if (Sout !== 1'b1) begin failures++; $display("FAIL short_sout got=%0d exp=1", Sout); end
        step(1, 0, 1'b1);
        checks++;
        if ({dt_short, fault, shoot_through} !== 3'b000) begin
            failures++; $display("FAIL short_clr got=%b exp=000", {dt_short, fault, shoot_through});
        end
        checks++;
        if (Sout !== 1'b1) begin failures++; $display("FAIL short_tracking got=%0d exp=1", Sout); end
        $display("txn short dt_last=%0d", dt_last);
    endtask

    task automatic test_shoot_through();
        // Leg is on the top side here.
        step(1, 1, 1'b0);
        hold(0, 0, 1 + X);
        checks++;
        if ({shoot_through, fault, dt_short} !== 3'b110) begin
            failures++; $display("FAIL shoot_flags got=%b exp=110", {shoot_through, fault, dt_short});
        end
        checks++;
        if (Sout !== 1'b1) begin failures++; $display("FAIL shoot_sout_held got=%0d exp=1", Sout); end
        hold(1, 1, 1 + X);
        step(1, 1, 1'b1);
        checks++;
        if (shoot_through !== 1'b1) begin failures++; $display("FAIL shoot_clr_while_11 got=%0d exp=1", shoot_through); end
        hold(0, 0, 1 + X);
        step(0, 0, 1'b1);
        checks++;
        if ({shoot_through, fault} !== 2'b00) begin
            failures++; $display("FAIL shoot_clr_after_00 got=%b exp=00", {shoot_through, fault});
        end
        checks++;
        if (Sout !== 1'b1) begin failures++; $display("FAIL shoot_sout_after_clr got=%0d exp=1", Sout); end
        // Back in OFF with no previous side: a short gap must not flag.
        hold(0, 0, 5);
        hold(0, 1, 1 + 1 + X);
        checks++;
        if ({Sout, dt_valid, dt_short} !== 3'b010) begin
            failures++; $display("FAIL shoot_recover got=%b exp=010", {Sout, dt_valid, dt_short});
        end
        $display("txn shoot_through recovered dt_last=%0d", dt_last);
    endtask

    task automatic test_direct();
        deadtime_min = 16'd0;
        hold(0, 1, 2);
        hold(1, 0, 1 + 1 + X);
        checks++;
        if (dt_last !== 16'd0) begin failures++; $display("FAIL direct_dt_last got=%0d exp=0", dt_last); end
        checks++;
        if ({dt_short, dt_valid, Sout} !== 3'b111) begin
            failures++; $display("FAIL direct_flags got=%b exp=111", {dt_short, dt_valid, Sout});
        end
        step(1, 0, 1'b1);
        $display("txn direct dt_last=%0d", dt_last);
    endtask

    task automatic test_saturation();
        do_reset();
        deadtime_min = 16'd25;
        hold(0, 0, 70000);
        hold(1, 0, 1 + 1 + X);
        checks++;
        if (dt_last !== 16'hFFFF) begin failures++; $display("FAIL sat_dt_last got=%0d exp=65535", dt_last); end
        checks++;
        if ({dt_valid, dt_short, Sout} !== 3'b101) begin
            failures++; $display("FAIL sat_flags got=%b exp=101", {dt_valid, dt_short, Sout});
        end
        $display("txn saturation dt_last=%0d", dt_last);
    endtask

    task automatic test_latency();
        do_reset();
        deadtime_min = 16'd25;
        hold(0, 0, 3);
        step(1, 0, 1'b0);
        checks++;
        if (Sout !== 1'b0) begin failures++; $display("FAIL latency_early1 got=%0d exp=0", Sout); end
`ifdef GATE_SYNC_EN
        step(1, 0, 1'b0);
        checks++;
        if (Sout !== 1'b0) begin failures++; $display("FAIL latency_early2 got=%0d exp=0", Sout); end
`endif
        step(1, 0, 1'b0);
        checks++;
        if ({Sout, dt_valid} !== 2'b11) begin failures++; $display("FAIL latency_response got=%b exp=11", {Sout, dt_valid}); end
        // First bottom-side turn-on after reset is never checked.
        do_reset();
        hold(0, 0, 3);
        hold(0, 1, 2 + X);
        checks++;
        if ({dt_valid, dt_short} !== 2'b10) begin failures++; $display("FAIL first_bot_unchecked got=%b exp=10", {dt_valid, dt_short}); end
        $display("txn latency edges=%0d", 2 + X);
    endtask

    task automatic test_async_reset();
        do_reset();
        deadtime_min = 16'd25;
        hold(0, 1, 3);
        hold(0, 0, 5);
        hold(1, 0, 2 + X);
        hold(0, 0, 4);
        checks++;
        if ({Sout, dt_short, dt_last} !== {1'b1, 1'b1, 16'd5}) begin
            failures++; $display("FAIL areset_setup got=%b/%b/%0d exp=1/1/5", Sout, dt_short, dt_last);
        end
        #3 RST = 1'b1;
        #1;
        checks++;
        if ({Sout, dt_last, dt_valid, shoot_through, dt_short, fault} !== '0) begin
            failures++;
            $display("FAIL areset_immediate got=%h exp=0", {Sout, dt_last, dt_valid, shoot_through, dt_short, fault});
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        model_reset();
        hold(0, 0, 3);
        hold(0, 1, 1 + 1 + X);
        checks++;
        if (dt_last !== 16'(4 + X)) begin failures++; $display("FAIL areset_count_discarded got=%0d exp=%0d", dt_last, 4 + X); end
        checks++;
        if (dt_short !== 1'b0) begin failures++; $display("FAIL areset_last_side got=%0d exp=0", dt_short); end
        $display("txn async_reset dt_last=%0d", dt_last);
    endtask

    task automatic test_random();
        logic [CNT_W+4:0] got, exp;
        int kind, len, errs;
        bit q1, q2, c;
        do_reset();
        deadtime_min = 16'($urandom_range(0, 30));
        errs = 0;
        for (int seg = 0; seg < 300; seg++) begin
            kind = $urandom_range(0, 99);
            if (kind < 40)      begin q1 = 1; q2 = 0; len = $urandom_range(1, 8); end
            else if (kind < 80) begin q1 = 0; q2 = 1; len = $urandom_range(1, 8); end
            else if (kind < 96) begin q1 = 0; q2 = 0; len = $urandom_range(0, 40); end
            else                begin q1 = 1; q2 = 1; len = $urandom_range(1, 2); end
            for (int i = 0; i < len; i++) begin
                c = ($urandom_range(0, 99) < 4) || (m_fault && $urandom_range(0, 9) == 0);
                step(q1, q2, c);
                got = {Sout, dt_last, dt_valid, shoot_through, dt_short, fault};
                exp = {m_sout, 16'(m_dtlast), m_dtv, m_st, m_ds, m_st | m_ds};
                checks++;
                if (got !== exp) begin
                    failures++;
                    errs++;
                    if (errs <= 10)
                        $display("FAIL random_cycle seg=%0d got=%h exp=%h", seg, got, exp);
                end
                if (dt_valid === 1'b1)
                    $display("txn random dt_last=%0d dt_short=%0d", dt_last, dt_short);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_short();
        test_shoot_through();
        test_direct();
        test_latency();
        test_async_reset();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
